// File: rtl/mem_arbiter_n.sv
// N-port memory arbiter: per-port request capture, fixed-priority or round-robin grant,
// one outstanding transaction on the core memory port, optional response timeout.
module mem_arbiter_n #(
    parameter  int NUM_PORTS  = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int ARB_MODE   = 0,
    parameter  int TIMEOUT    = 0,
    localparam int SW         = DATA_WIDTH / 8,
    localparam int GW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            m_valid,
    input  logic [NUM_PORTS-1:0]            m_instr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_PORTS*SW-1:0]         m_wstrb,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic [NUM_PORTS-1:0]            m_ready,
    output logic [NUM_PORTS-1:0]            m_error,
    output logic [NUM_PORTS-1:0]            m_overrun,
    output logic                            memory_valid,
    output logic                            memory_instr,
    output logic [ADDR_WIDTH-1:0]           memory_addr,
    output logic [DATA_WIDTH-1:0]           memory_wdata,
    output logic [SW-1:0]                   memory_wstrb,
    input  logic [DATA_WIDTH-1:0]           memory_rdata,
    input  logic                            memory_ready,
    output logic [GW-1:0]                   grant_id,
    output logic                            busy
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TCNT_MAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [NUM_PORTS-1:0]   r_pend;
    logic [NUM_PORTS-1:0]   r_binstr;
    logic [ADDR_WIDTH-1:0]  r_baddr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  r_bwdata [NUM_PORTS];
    logic [SW-1:0]          r_bwstrb [NUM_PORTS];

    logic [GW-1:0]          r_ptr;
    logic [GW-1:0]          r_grant;
    logic [TW-1:0]          r_tcnt;

    logic                   r_mem_valid;
    logic                   r_mem_instr;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_wdata;
    logic [SW-1:0]          r_mem_wstrb;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [NUM_PORTS-1:0]   r_m_ready;
    logic [NUM_PORTS-1:0]   r_m_error;
    logic [NUM_PORTS-1:0]   r_ovr;

    logic [NUM_PORTS-1:0]   w_cap;
    logic [NUM_PORTS-1:0]   w_req;
    logic [NUM_PORTS-1:0]   w_clr;
    logic [GW-1:0]          w_win;
    logic                   w_found;
    logic                   w_grant;
    logic                   w_done;
    logic                   w_expire;
    logic                   w_sel_instr;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic [SW-1:0]          w_sel_wstrb;

    // A request arriving this cycle is eligible immediately, alongside buffered ones.
    always_comb begin : p_arb
        int j;
        j       = 0;
        w_cap   = m_valid & ~r_pend;
        w_req   = r_pend | w_cap;
        w_win   = '0;
        w_found = 1'b0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (w_req[i]) begin
                    w_win   = GW'(i);
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_PORTS; k >= 1; k--) begin
                j = int'(r_ptr) + k;
                if (j >= NUM_PORTS) j = j - NUM_PORTS;
                if (w_req[j]) begin
                    w_win   = GW'(j);
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (r_pend[w_win]) begin
            w_sel_instr = r_binstr[w_win];
            w_sel_addr  = r_baddr[w_win];
            w_sel_wdata = r_bwdata[w_win];
            w_sel_wstrb = r_bwstrb[w_win];
        end else begin
            w_sel_instr = m_instr[w_win];
            w_sel_addr  = m_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_wdata = m_wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
            w_sel_wstrb = m_wstrb[int'(w_win)*SW +: SW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Ready on the expiry cycle wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_expire    = 1'b0;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_expire = (TIMEOUT > 0) && (r_tcnt == TCNT_MAX) && !memory_ready;
                if (memory_ready || w_expire) begin
                    w_done         = 1'b1;
                    w_clr[r_grant] = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            r_binstr    <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_baddr[i]  <= '0;
                r_bwdata[i] <= '0;
                r_bwstrb[i] <= '0;
            end
            r_ptr       <= GW'(NUM_PORTS - 1);
            r_grant     <= '0;
            r_tcnt      <= '0;
            r_mem_valid <= 1'b0;
            r_mem_instr <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_rdata     <= '0;
            r_m_ready   <= '0;
            r_m_error   <= '0;
            r_ovr       <= '0;
        end else begin
            r_m_ready <= '0;
            r_m_error <= '0;
            r_ovr     <= m_valid & r_pend;
            r_pend    <= (r_pend | w_cap) & ~w_clr;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_cap[i]) begin
                    r_binstr[i] <= m_instr[i];
                    r_baddr[i]  <= m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    r_bwdata[i] <= m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    r_bwstrb[i] <= m_wstrb[i*SW +: SW];
                end
            end
            if (w_grant) begin
                r_mem_valid <= 1'b1;
                r_mem_instr <= w_sel_instr;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_mem_wstrb <= w_sel_wstrb;
                r_grant     <= w_win;
                r_tcnt      <= '0;
                if (ARB_MODE != 0) r_ptr <= w_win;
            end else if (r_state == ST_WAIT && !w_done) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_done) begin
                r_mem_valid        <= 1'b0;
                r_m_ready[r_grant] <= 1'b1;
                r_m_error[r_grant] <= w_expire;
                r_rdata            <= w_expire ? '0 : memory_rdata;
            end
        end
    end

    assign m_rdata      = r_rdata;
    assign m_ready      = r_m_ready;
    assign m_error      = r_m_error;
    assign m_overrun    = r_ovr;
    assign memory_valid = r_mem_valid;
    assign memory_instr = r_mem_instr;
    assign memory_addr  = r_mem_addr;
    assign memory_wdata = r_mem_wdata;
    assign memory_wstrb = r_mem_wstrb;
    assign grant_id     = r_grant;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: four instances cover the default, fixed-priority,
// round-robin and timeout configurations.
module tb_mem_arbiter_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: 2 ports, 32-bit, fixed priority, no timeout
    logic [1:0]  a_valid = '0, a_instr = '0;
    logic [63:0] a_addr = '0, a_wdata = '0;
    logic [7:0]  a_wstrb = '0;
    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic [31:0] a_mrdata = '0;
    logic [1:0]  a_ready, a_error, a_ovr;
    logic        a_mvalid, a_minstr, a_busy;
    logic        a_mready = 1'b0;
    logic [3:0]  a_mwstrb;
    logic [0:0]  a_gid;

    // Instance B: 4 ports, 16-bit, fixed priority
    logic [3:0]  b_valid = '0, b_instr = '0;
    logic [63:0] b_addr = '0, b_wdata = '0;
    logic [7:0]  b_wstrb = '0;
    logic [15:0] b_rdata, b_maddr, b_mwdata;
    logic [15:0] b_mrdata = '0;
    logic [3:0]  b_ready, b_error, b_ovr;
    logic        b_mvalid, b_minstr, b_busy;
    logic        b_mready = 1'b0;
    logic [1:0]  b_mwstrb;
    logic [1:0]  b_gid;

    // Instance C: 3 ports, 16-bit, round robin
    logic [2:0]  c_valid = '0, c_instr = '0;
    logic [47:0] c_addr = '0, c_wdata = '0;
    logic [5:0]  c_wstrb = '0;
    logic [15:0] c_rdata, c_maddr, c_mwdata;
    logic [15:0] c_mrdata = '0;
    logic [2:0]  c_ready, c_error, c_ovr;
    logic        c_mvalid, c_minstr, c_busy;
    logic        c_mready = 1'b0;
    logic [1:0]  c_mwstrb;
    logic [1:0]  c_gid;

    // Instance D: 2 ports, 16-bit, timeout 4
    logic [1:0]  d_valid = '0, d_instr = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic [15:0] d_rdata, d_maddr, d_mwdata;
    logic [15:0] d_mrdata = '0;
    logic [1:0]  d_ready, d_error, d_ovr;
    logic        d_mvalid, d_minstr, d_busy;
    logic        d_mready = 1'b0;
    logic [1:0]  d_mwstrb;
    logic [0:0]  d_gid;

    mem_arbiter_n #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT(0)) dut_a (
        .clk(clk), .rst(rst), .m_valid(a_valid), .m_instr(a_instr), .m_addr(a_addr),
        .m_wdata(a_wdata), .m_wstrb(a_wstrb), .m_rdata(a_rdata), .m_ready(a_ready),
        .m_error(a_error), .m_overrun(a_ovr), .memory_valid(a_mvalid), .memory_instr(a_minstr),
        .memory_addr(a_maddr), .memory_wdata(a_mwdata), .memory_wstrb(a_mwstrb),
        .memory_rdata(a_mrdata), .memory_ready(a_mready), .grant_id(a_gid), .busy(a_busy));

    mem_arbiter_n #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(16), .ARB_MODE(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .m_valid(b_valid), .m_instr(b_instr), .m_addr(b_addr),
        .m_wdata(b_wdata), .m_wstrb(b_wstrb), .m_rdata(b_rdata), .m_ready(b_ready),
        .m_error(b_error), .m_overrun(b_ovr), .memory_valid(b_mvalid), .memory_instr(b_minstr),
        .memory_addr(b_maddr), .memory_wdata(b_mwdata), .memory_wstrb(b_mwstrb),
        .memory_rdata(b_mrdata), .memory_ready(b_mready), .grant_id(b_gid), .busy(b_busy));

    mem_arbiter_n #(.NUM_PORTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(16), .ARB_MODE(1), .TIMEOUT(0)) dut_c (
        .clk(clk), .rst(rst), .m_valid(c_valid), .m_instr(c_instr), .m_addr(c_addr),
        .m_wdata(c_wdata), .m_wstrb(c_wstrb), .m_rdata(c_rdata), .m_ready(c_ready),
        .m_error(c_error), .m_overrun(c_ovr), .memory_valid(c_mvalid), .memory_instr(c_minstr),
        .memory_addr(c_maddr), .memory_wdata(c_mwdata), .memory_wstrb(c_mwstrb),
        .memory_rdata(c_mrdata), .memory_ready(c_mready), .grant_id(c_gid), .busy(c_busy));

    mem_arbiter_n #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16), .ARB_MODE(0), .TIMEOUT(4)) dut_d (
        .clk(clk), .rst(rst), .m_valid(d_valid), .m_instr(d_instr), .m_addr(d_addr),
        .m_wdata(d_wdata), .m_wstrb(d_wstrb), .m_rdata(d_rdata), .m_ready(d_ready),
        .m_error(d_error), .m_overrun(d_ovr), .memory_valid(d_mvalid), .memory_instr(d_minstr),
        .memory_addr(d_maddr), .memory_wdata(d_mwdata), .memory_wstrb(d_mwstrb),
        .memory_rdata(d_mrdata), .memory_ready(d_mready), .grant_id(d_gid), .busy(d_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int          exp_rr [5] = '{0, 1, 2, 0, 1};
    logic [2:0]  exp_rdy;

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_mvalid", a_mvalid, 0);
        chk("rst_busy",   a_busy,   0);
        chk("rst_gid",    a_gid,    0);
        chk("rst_rdata",  a_rdata,  0);
        chk("rst_ready",  a_ready,  0);
        chk("rst_ptr_b",  b_mvalid, 0);

        // Single read on port 1
        a_valid = 2'b10; a_instr = 2'b10; a_addr[63:32] = 32'h0000_1000;
        tick();
        a_valid = 2'b00; a_instr = 2'b00;
        chk("rd_mvalid", a_mvalid, 1);
        chk("rd_maddr",  a_maddr,  32'h1000);
        chk("rd_minstr", a_minstr, 1);
        chk("rd_gid",    a_gid,    1);
        chk("rd_busy",   a_busy,   1);
        tick();
        chk("rd_hold",   a_mvalid, 1);
        a_mready = 1'b1; a_mrdata = 32'hDEAD_BEEF;
        tick();
        a_mready = 1'b0;
        chk("rd_ready",  a_ready,  2'b10);
        chk("rd_rdata",  a_rdata,  32'hDEAD_BEEF);
        chk("rd_vdrop",  a_mvalid, 0);
        chk("rd_idle",   a_busy,   0);
        chk("rd_noerr",  a_error,  0);
        tick();
        chk("rd_pulse",  a_ready,  0);

        // Overrun on port 0
        a_valid = 2'b01; a_addr[31:0] = 32'h0000_2000;
        tick();
        a_addr[31:0] = 32'h0000_3000;
        tick();
        a_valid = 2'b00;
        chk("ov_pulse",  a_ovr,   2'b01);
        chk("ov_addr",   a_maddr, 32'h2000);
        tick();
        chk("ov_once",   a_ovr,   2'b00);
        chk("ov_addr2",  a_maddr, 32'h2000);
        a_mready = 1'b1; a_mrdata = 32'h11;
        tick();
        a_mready = 1'b0;
        chk("ov_ready",  a_ready, 2'b01);
        chk("ov_rdata",  a_rdata, 32'h11);
        tick();
        chk("ov_nomore", a_mvalid, 0);
        chk("ov_addr3",  a_maddr, 32'h2000);

        // Fixed priority, ports 1,2,3 together
        b_addr = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
        b_valid = 4'b1110;
        tick();
        b_valid = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            chk("fp_gid",   b_gid,    k);
            chk("fp_addr",  b_maddr,  k * 16'h0100);
            chk("fp_valid", b_mvalid, 1);
            tick();
            b_mready = 1'b1;
            tick();
            b_mready = 1'b0;
            chk("fp_ready", b_ready,  4'b0001 << k);
            chk("fp_gap",   b_mvalid, 0);
            tick();
        end
        chk("fp_done", b_busy, 0);

        // Round robin with all ports requesting
        c_valid = 3'b111; c_mready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gid",   c_gid,    exp_rr[k]);
            chk("rr_valid", c_mvalid, 1);
            tick();
            exp_rdy = 3'b001 << exp_rr[k];
            chk("rr_ready", c_ready,  exp_rdy);
        end
        c_valid = 3'b000; c_mready = 1'b0;

        // Timeout expiry with no ready
        d_valid = 2'b01; d_addr[15:0] = 16'h0077; d_mrdata = 16'hABCD;
        tick();
        d_valid = 2'b00;
        chk("to_busy", d_busy, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_wait",  d_mvalid, 1);
            chk("to_nordy", d_ready,  0);
        end
        tick();
        chk("to_ready", d_ready,  2'b01);
        chk("to_error", d_error,  2'b01);
        chk("to_rdata", d_rdata,  0);
        chk("to_busy0", d_busy,   0);
        chk("to_vdrop", d_mvalid, 0);
        tick();
        chk("to_epulse", d_error, 0);

        // Ready on the expiry cycle: normal completion
        d_valid = 2'b10;
        tick();
        d_valid = 2'b00;
        repeat (3) tick();
        d_mready = 1'b1; d_mrdata = 16'h5A5A;
        tick();
        d_mready = 1'b0;
        chk("tp_ready", d_ready, 2'b10);
        chk("tp_error", d_error, 2'b00);
        chk("tp_rdata", d_rdata, 16'h5A5A);

        // Asynchronous reset during WAIT
        a_valid = 2'b10; a_addr[63:32] = 32'h40;
        tick();
        a_valid = 2'b00;
        chk("ar_busy1", a_busy, 1);
        chk("ar_gid1",  a_gid,  1);
        #2 rst = 1'b1;
        #1;
        chk("ar_mvalid", a_mvalid, 0);
        chk("ar_busy",   a_busy,   0);
        chk("ar_ready",  a_ready,  0);
        chk("ar_gid",    a_gid,    0);
        tick();
        rst = 1'b0;
        a_valid = 2'b01; a_addr[31:0] = 32'h50;
        tick();
        a_valid = 2'b00;
        chk("ar_again",  a_mvalid, 1);
        chk("ar_addr",   a_maddr,  32'h50);
        chk("ar_gid0",   a_gid,    0);
        a_mready = 1'b1; a_mrdata = 32'h77;
        tick();
        a_mready = 1'b0;
        chk("ar_rdy",    a_ready,  2'b01);
        chk("ar_rdata",  a_rdata,  32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
